datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 151 +++++++++++++++
 tb/tb_datapath.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// 32-bit CPU datapath: register file, special registers, shared bus, ALU and Z result register.
// The bus is combinational and every register captures the pre-edge bus value on the same clk edge.
module datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] R_rd,
  input  logic [15:0] R_wrt,
  input  logic        HI_out,
  input  logic        LO_out,
  input  logic        Zhi_out,
  input  logic        Zlo_out,
  input  logic        PC_out,
  input  logic        MDR_out,
  input  logic        MAR_out,
  input  logic        In_out,
  input  logic        C_out,
  input  logic        MAR_rd,
  input  logic        Zlo_rd,
  input  logic        PC_rd,
  input  logic        MDR_rd,
  input  logic        IR_rd,
  input  logic        Y_rd,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  op_sel,
  input  logic [31:0] Mdatain,
  output logic [31:0] r3_view,
  output logic [31:0] r4_view,
  output logic [31:0] r7_view,
  output logic [31:0] Y_view,
  output logic [31:0] Zlo_view,
  output logic [31:0] MDR_view,
  output logic [31:0] PC_view,
  output logic [31:0] BusMuxOut,
  output logic [31:0] Data_view
);

  localparam int unsigned W     = 32;
  localparam int unsigned NREG  = 16;
  localparam int unsigned IMM_W = 19;

  logic [W-1:0]     r_q [NREG];
  logic [W-1:0]     hi_q, lo_q, in_q, pc_q, mar_q, mdr_q, y_q;
  logic [IMM_W-1:0] ir_q;  // only the immediate field of IR is ever observed
  logic [2*W-1:0]   z_q;

  logic [W-1:0]     pc_d;
  logic [2*W-1:0]   z_d;
  logic [W-1:0]     c_sext;
  logic [W-1:0]     alu_a, alu_b;
  logic [4:0]       sh_amt;
  logic [2*W-1:0]   rot;

  assign c_sext = {{(W-IMM_W){ir_q[IMM_W-1]}}, ir_q};

  // Bus mux: later assignments win, so R0 ends up with the highest priority and MAR the lowest.
  always_comb begin
    BusMuxOut = '0;
    if (MAR_out) BusMuxOut = mar_q;
    if (C_out)   BusMuxOut = c_sext;
    if (In_out)  BusMuxOut = in_q;
    if (MDR_out) BusMuxOut = mdr_q;
    if (PC_out)  BusMuxOut = pc_q;
    if (Zlo_out) BusMuxOut = z_q[W-1:0];
    if (Zhi_out) BusMuxOut = z_q[2*W-1:W];
    if (LO_out)  BusMuxOut = lo_q;
    if (HI_out)  BusMuxOut = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (R_wrt[i]) BusMuxOut = r_q[i];
    end
  end

  assign Data_view = Read ? Mdatain : BusMuxOut;

  // ALU: A from Y, B from the bus; upper half of Z is zero except for div and mul.
  always_comb begin
    z_d    = '0;
    rot    = '0;
    alu_a  = y_q;
    alu_b  = BusMuxOut;
    sh_amt = alu_b[4:0];
    case (op_sel)
      5'b00011, 5'b01100: z_d[W-1:0] = alu_a + alu_b;
      5'b00100:           z_d[W-1:0] = alu_a - alu_b;
      5'b00101, 5'b01101: z_d[W-1:0] = alu_a & alu_b;
      5'b00110, 5'b01110: z_d[W-1:0] = alu_a | alu_b;
      5'b00111: begin
        rot        = {alu_a, alu_a} >> sh_amt;
        z_d[W-1:0] = rot[W-1:0];
      end
      5'b01000: begin
        rot        = {alu_a, alu_a} << sh_amt;
        z_d[W-1:0] = rot[2*W-1:W];
      end
      5'b01001: z_d[W-1:0] = alu_a >> sh_amt;
      5'b01010: z_d[W-1:0] = W'($signed(alu_a) >>> sh_amt);
      5'b01011: z_d[W-1:0] = alu_a << sh_amt;
      5'b01111: begin
        if (alu_b != '0) begin
          z_d[W-1:0]   = W'($signed(alu_a) / $signed(alu_b));
          z_d[2*W-1:W] = W'($signed(alu_a) % $signed(alu_b));
        end
      end
      5'b10000: z_d = $signed({{W{alu_a[W-1]}}, alu_a}) * $signed({{W{alu_b[W-1]}}, alu_b});
      5'b10001: z_d[W-1:0] = W'(0) - alu_b;
      5'b10010: z_d[W-1:0] = ~alu_b;
      default:  z_d = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (PC_rd)      pc_d = BusMuxOut;
    else if (IncPC) pc_d = pc_q + W'(1);
  end

  // HI, LO and InPort have no load path and therefore stay at zero.
  always_ff @(posedge clk) begin
    hi_q <= '0;
    lo_q <= '0;
    in_q <= '0;
    if (clr) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (R_rd[i]) r_q[i] <= BusMuxOut;
      end
      pc_q <= pc_d;
      if (IR_rd)  ir_q  <= BusMuxOut[IMM_W-1:0];
      if (MAR_rd) mar_q <= BusMuxOut;
      if (MDR_rd) mdr_q <= Data_view;
      if (Y_rd)   y_q   <= BusMuxOut;
      if (Zlo_rd) z_q   <= z_d;
    end
  end

  assign r3_view  = r_q[3];
  assign r4_view  = r_q[4];
  assign r7_view  = r_q[7];
  assign Y_view   = y_q;
  assign Zlo_view = z_q[W-1:0];
  assign MDR_view = mdr_q;
  assign PC_view  = pc_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: register transfers, bus priority, PC update, ALU ops and clear.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] R_rd, R_wrt;
  logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read;
  logic [4:0]  op_sel;
  logic [31:0] Mdatain;
  logic [31:0] r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view;
  logic [31:0] BusMuxOut, Data_view;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } alu_vec_t;

  datapath dut (
    .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
    .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
    .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
    .Y_rd(Y_rd), .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .Mdatain(Mdatain),
    .r3_view(r3_view), .r4_view(r4_view), .r7_view(r7_view), .Y_view(Y_view),
    .Zlo_view(Zlo_view), .MDR_view(MDR_view), .PC_view(PC_view),
    .BusMuxOut(BusMuxOut), .Data_view(Data_view)
  );

  always #5 clk = ~clk;

  task automatic idle();
    clr = 1'b0; R_rd = '0; R_wrt = '0;
    HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
    MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
    MAR_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0;
    IncPC = 0; Read = 0; op_sel = '0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    Mdatain = v; Read = 1; MDR_rd = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    string       nm  [8];
    idle();
    Mdatain = 32'h0000_1234; Read = 1; MDR_rd = 1; IncPC = 1;
    R_rd = '1; Y_rd = 1; Zlo_rd = 1; IR_rd = 1; MAR_rd = 1;
    clr = 1;
    tick();
    n_tests++;
    if (Data_view !== 32'h0000_1234) begin
      n_fail++; $display("FAIL reset_data_view: got %h expected %h", Data_view, 32'h0000_1234);
    end
    idle();
    #1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h0);
    got = '{r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view, BusMuxOut};
    nm  = '{"r3", "r4", "r7", "Y", "Zlo", "MDR", "PC", "bus"};
    for (int i = 0; i < 8; i++) begin
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got[i] !== exp_v) begin
        n_fail++; $display("FAIL reset_%s: got %h expected %h", nm[i], got[i], exp_v);
      end
    end
  endtask

  task automatic test_load_regs();
    logic [31:0] vals [3];
    int          idxs [3];
    logic [31:0] got;
    vals = '{32'h99, 32'h14, 32'hF6};
    idxs = '{3, 4, 7};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      load_mdr(vals[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (MDR_view !== exp_v) begin
        n_fail++; $display("FAIL load_mdr_%0d: got %h expected %h", i, MDR_view, exp_v);
      end
      MDR_out = 1; R_rd[idxs[i]] = 1'b1;
      exp_q.push_back(vals[i]);
      tick();
      idle();
      got = (idxs[i] == 3) ? r3_view : (idxs[i] == 4) ? r4_view : r7_view;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL load_r%0d: got %h expected %h", idxs[i], got, exp_v);
      end
    end
  endtask

  task automatic test_and();
    load_mdr(32'h2A2B_8000);
    MDR_out = 1; IR_rd = 1;
    tick();
    idle();
    C_out = 1;
    exp_q.push_back(32'h0003_8000);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL c_sext_pos: got %h expected %h", BusMuxOut, exp_v);
    end
    idle();
    R_wrt[3] = 1; Y_rd = 1;
    exp_q.push_back(32'h99);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (Y_view !== exp_v) begin
      n_fail++; $display("FAIL and_y: got %h expected %h", Y_view, exp_v);
    end
    R_wrt[7] = 1; op_sel = 5'b00101; Zlo_rd = 1;
    exp_q.push_back(32'h90);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (Zlo_view !== exp_v) begin
      n_fail++; $display("FAIL and_zlo: got %h expected %h", Zlo_view, exp_v);
    end
    Zlo_out = 1; R_rd[4] = 1;
    exp_q.push_back(32'h90);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (r4_view !== exp_v) begin
      n_fail++; $display("FAIL and_r4: got %h expected %h", r4_view, exp_v);
    end
    // Bit 18 set: the immediate must sign-extend with ones.
    load_mdr(32'h0004_0000);
    MDR_out = 1; IR_rd = 1;
    tick();
    idle();
    C_out = 1;
    exp_q.push_back(32'hFFFC_0000);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL c_sext_neg: got %h expected %h", BusMuxOut, exp_v);
    end
    idle();
  endtask

  task automatic test_priority();
    R_wrt[3] = 1; MDR_out = 1;
    exp_q.push_back(32'h99);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL prio_r3_mdr: got %h expected %h", BusMuxOut, exp_v);
    end
    R_wrt = 16'h0088;
    exp_q.push_back(32'h99);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL prio_r3_r7: got %h expected %h", BusMuxOut, exp_v);
    end
    idle();
    MDR_out = 1;
    exp_q.push_back(32'h0004_0000);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (Data_view !== exp_v) begin
      n_fail++; $display("FAIL data_view_bus: got %h expected %h", Data_view, exp_v);
    end
    idle();
    R_wrt[7] = 1; MAR_rd = 1;
    tick();
    idle();
    MAR_out = 1;
    exp_q.push_back(32'hF6);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL mar_out: got %h expected %h", BusMuxOut, exp_v);
    end
    MDR_out = 1;
    exp_q.push_back(32'h0004_0000);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL prio_mdr_mar: got %h expected %h", BusMuxOut, exp_v);
    end
    idle();
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL bus_idle: got %h expected %h", BusMuxOut, exp_v);
    end
  endtask

  task automatic test_pc();
    load_mdr(32'hF6);
    MDR_out = 1; PC_rd = 1;
    exp_q.push_back(32'hF6);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (PC_view !== exp_v) begin
      n_fail++; $display("FAIL pc_load: got %h expected %h", PC_view, exp_v);
    end
    IncPC = 1;
    exp_q.push_back(32'hF7);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (PC_view !== exp_v) begin
      n_fail++; $display("FAIL pc_inc: got %h expected %h", PC_view, exp_v);
    end
    PC_out = 1;
    exp_q.push_back(32'hF7);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (BusMuxOut !== exp_v) begin
      n_fail++; $display("FAIL pc_out: got %h expected %h", BusMuxOut, exp_v);
    end
    idle();
    MDR_out = 1; PC_rd = 1; IncPC = 1;
    exp_q.push_back(32'hF6);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (PC_view !== exp_v) begin
      n_fail++; $display("FAIL pc_rd_wins: got %h expected %h", PC_view, exp_v);
    end
    load_mdr(32'hFFFF_FFFF);
    MDR_out = 1; PC_rd = 1;
    tick();
    idle();
    IncPC = 1;
    exp_q.push_back(32'h0);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (PC_view !== exp_v) begin
      n_fail++; $display("FAIL pc_wrap: got %h expected %h", PC_view, exp_v);
    end
  endtask

  task automatic test_alu_ops();
    alu_vec_t v [21];
    v = '{
      '{5'b00011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0000_0001},
      '{5'b00100, 32'h0000_0005, 32'h0000_0007, 32'h0, 32'hFFFF_FFFE},
      '{5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000},
      '{5'b00110, 32'hF0F0_F0F0, 32'h0F00_00FF, 32'h0, 32'hFFF0_F0FF},
      '{5'b00111, 32'h1234_5678, 32'h0000_0024, 32'h0, 32'h8123_4567},
      '{5'b01000, 32'h1234_5678, 32'h0000_0008, 32'h0, 32'h3456_7812},
      '{5'b01001, 32'h8000_0000, 32'h0000_003F, 32'h0, 32'h0000_0001},
      '{5'b01010, 32'h8000_0000, 32'h0000_0004, 32'h0, 32'hF800_0000},
      '{5'b01011, 32'h0000_0001, 32'h0000_0021, 32'h0, 32'h0000_0002},
      '{5'b01100, 32'h0000_0010, 32'h0000_0020, 32'h0, 32'h0000_0030},
      '{5'b01101, 32'h0000_00FF, 32'h0000_000F, 32'h0, 32'h0000_000F},
      '{5'b01110, 32'h0000_00F0, 32'h0000_000F, 32'h0, 32'h0000_00FF},
      '{5'b01111, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003},
      '{5'b01111, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{5'b01111, 32'h0000_0007, 32'h0000_0000, 32'h0, 32'h0},
      '{5'b10000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{5'b10000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0},
      '{5'b10001, 32'h0000_0000, 32'h0000_0005, 32'h0, 32'hFFFF_FFFB},
      '{5'b10010, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0},
      '{5'b00000, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0},
      '{5'b11111, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0}
    };
    for (int i = 0; i < 21; i++) begin
      load_mdr(v[i].a);
      MDR_out = 1; Y_rd = 1;
      tick();
      load_mdr(v[i].b);
      MDR_out = 1; op_sel = v[i].op; Zlo_rd = 1;
      exp_q.push_back(v[i].lo);
      exp_q.push_back(v[i].hi);
      tick();
      idle();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (Zlo_view !== exp_v) begin
        n_fail++; $display("FAIL alu_lo[%0d] op=%b: got %h expected %h", i, v[i].op, Zlo_view, exp_v);
      end
      Zhi_out = 1;
      #1;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (BusMuxOut !== exp_v) begin
        n_fail++; $display("FAIL alu_hi[%0d] op=%b: got %h expected %h", i, v[i].op, BusMuxOut, exp_v);
      end
      idle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [4];
    load_mdr(32'hAAAA_5555);
    MDR_out = 1; R_rd[7] = 1; Y_rd = 1; PC_rd = 1;
    MDR_rd = 1; Read = 1; Mdatain = 32'h1234_5678;
    exp_q.push_back(32'hAAAA_5555);
    exp_q.push_back(32'hAAAA_5555);
    exp_q.push_back(32'hAAAA_5555);
    exp_q.push_back(32'h1234_5678);
    tick();
    idle();
    got = '{r7_view, Y_view, PC_view, MDR_view};
    for (int i = 0; i < 4; i++) begin
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got[i] !== exp_v) begin
        n_fail++; $display("FAIL simul_load[%0d]: got %h expected %h", i, got[i], exp_v);
      end
    end
  endtask

  task automatic test_clear_override();
    logic [31:0] got [7];
    MDR_out = 1; R_rd = '1; Y_rd = 1; IncPC = 1; Zlo_rd = 1; op_sel = 5'b00011;
    MDR_rd = 1; Read = 1; Mdatain = 32'hDEAD_BEEF; clr = 1;
    for (int i = 0; i < 7; i++) exp_q.push_back(32'h0);
    tick();
    idle();
    got = '{r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view};
    for (int i = 0; i < 7; i++) begin
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got[i] !== exp_v) begin
        n_fail++; $display("FAIL clr_override[%0d]: got %h expected %h", i, got[i], exp_v);
      end
    end
  endtask

  initial begin
    idle();
    clr = 1;
    tick();
    test_reset();
    test_load_regs();
    test_and();
    test_priority();
    test_pc();
    test_alu_ops();
    test_back_to_back();
    test_clear_override();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
